// File: rtl/cpu_sys_nios2_oci_dct_ctrl.sv
// OCI DCT trace buffer sequencer: packs 2-bit codes into 30-bit packets and drains at end of test.
// Optional DCT_TIMESTAMP_EN adds out_stamp, a 16-bit cycle count captured with each packet.
//
// state  | meaning
// IDLE   | capture disabled, buffer contents retained
// RUN    | capturing DCT codes
// DRAIN  | end of test: flush remaining data, codes ignored
// ENDED  | drain complete, test_has_ended held until reset
module cpu_sys_nios2_oci_dct_ctrl #(
  parameter int DEPTH   = 15,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trc_en,
  input  logic        dct_valid,
  input  logic [1:0]  dct_code,
  input  logic        flush_req,
  input  logic        test_ending,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [29:0] out_buffer,
  output logic [3:0]  out_count,
  output logic        overflow,
  output logic        busy,
  output logic        test_has_ended
`ifdef DCT_TIMESTAMP_EN
  ,
  output logic [15:0] out_stamp
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_ENDED = 2'd3;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [3:0]    DEPTH_C  = 4'(DEPTH);

  logic [1:0]    state, state_n;
  logic [29:0]   pkt_buf;
  logic [3:0]    cnt;
  logic [TW-1:0] timer;
  logic          flush_pend;
  logic          full, nonempty, tmr_exp, launch, xfer, capture, accept;

  assign full     = (cnt == DEPTH_C);
  assign nonempty = (cnt != 4'd0);
  assign tmr_exp  = (TIMEOUT != 0) && (timer == TMR_LAST);
  assign launch   = full || (nonempty && (flush_pend || tmr_exp || state == S_DRAIN));
  assign xfer     = launch && (!out_valid || out_ready);
  assign capture  = (state == S_RUN) && dct_valid;
  // A full buffer can still take a code if it is being launched this cycle.
  assign accept   = capture && (!full || xfer);

  assign busy           = nonempty || out_valid || flush_pend;
  assign test_has_ended = (state == S_ENDED);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (test_ending) state_n = S_DRAIN;
               else if (trc_en) state_n = S_RUN;
      S_RUN:   if (test_ending) state_n = S_DRAIN;
               else if (!trc_en) state_n = S_IDLE;
      S_DRAIN: if (!nonempty && !out_valid) state_n = S_ENDED;
      default: state_n = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pkt_buf    <= '0;
      cnt        <= '0;
      timer      <= '0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_buffer <= '0;
      out_count  <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_n;

      if (xfer) begin
        out_valid  <= 1'b1;
        out_buffer <= pkt_buf;
        out_count  <= cnt;
        pkt_buf    <= accept ? {28'b0, dct_code} : 30'b0;
        cnt        <= accept ? 4'd1 : 4'd0;
      end else begin
        if (out_valid && out_ready)
          out_valid <= 1'b0;
        if (accept) begin
          pkt_buf <= {pkt_buf[27:0], dct_code};
          cnt     <= cnt + 4'd1;
        end
      end

      // An empty buffer is never launched, so a flush request against it is dropped.
      flush_pend <= !xfer && (flush_pend || flush_req) && nonempty;

      if (accept || xfer)
        timer <= '0;
      else if (nonempty && !tmr_exp)
        timer <= timer + TW'(1);

      if (capture && full && !xfer)
        overflow <= 1'b1;
    end
  end

`ifdef DCT_TIMESTAMP_EN
  logic [15:0] stamp_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stamp_cnt <= '0;
      out_stamp <= '0;
    end else begin
      stamp_cnt <= stamp_cnt + 16'd1;
      if (xfer)
        out_stamp <= stamp_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_sys_nios2_oci_dct_ctrl.sv
// Scoreboard bench for the DCT trace sequencer: directed stimulus pushes expected packets,
// a negedge monitor pops and compares on every accepted packet.
module tb_cpu_sys_nios2_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trc_en = 1'b0;
  logic        dct_valid = 1'b0;
  logic [1:0]  dct_code = 2'b00;
  logic        flush_req = 1'b0;
  logic        test_ending = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [29:0] out_buffer;
  logic [3:0]  out_count;
  logic        overflow;
  logic        busy;
  logic        test_has_ended;
`ifdef DCT_TIMESTAMP_EN
  logic [15:0] out_stamp;
`endif

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  cpu_sys_nios2_oci_dct_ctrl dut (
    .clk(clk),
    .reset(reset),
    .trc_en(trc_en),
    .dct_valid(dct_valid),
    .dct_code(dct_code),
    .flush_req(flush_req),
    .test_ending(test_ending),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_buffer(out_buffer),
    .out_count(out_count),
    .overflow(overflow),
    .busy(busy),
    .test_has_ended(test_has_ended)
`ifdef DCT_TIMESTAMP_EN
    ,
    .out_stamp(out_stamp)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted packet is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_packet: got count %0d buffer 0x%0h, expected none",
                 out_count, out_buffer);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("pkt_count", 32'(out_count), 32'(e[33:30]));
        check("pkt_buffer", 32'(out_buffer), 32'(e[29:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [1:0] code);
    dct_code  = code;
    dct_valid = 1'b1;
    tick();
    dct_valid = 1'b0;
  endtask

  task automatic expect_pkt(input logic [3:0] c, input logic [29:0] b);
    exp_q.push_back({c, b});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_buffer"}, 32'(out_buffer), 32'd0);
    check({tag, "_out_count"}, 32'(out_count), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ended"}, 32'(test_has_ended), 32'd0);
  endtask

  initial begin
    int n;

    repeat (3) tick();
    check_all_zero("reset");

    // Full packet of 01 codes.
    reset = 1'b0;
    trc_en = 1'b1;
    out_ready = 1'b1;
    tick();
    expect_pkt(4'd15, 30'h15555555);
    for (int i = 0; i < 15; i++) send_code(2'b01);
    wait_drain("full_drain");
    check("full_overflow", 32'(overflow), 32'd0);

    // Stalled sink: second full buffer cannot launch, the extra code is dropped.
    out_ready = 1'b0;
    expect_pkt(4'd15, 30'h2AAAAAAA);
    expect_pkt(4'd15, 30'h3FFFFFFF);
    for (int i = 0; i < 15; i++) send_code(2'b10);
    for (int i = 0; i < 15; i++) send_code(2'b11);
    send_code(2'b11);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_held_valid", 32'(out_valid), 32'd1);
    check("ovf_held_count", 32'(out_count), 32'd15);
    check("ovf_held_buffer", 32'(out_buffer), 32'h2AAAAAAA);
    repeat (4) tick();
    check("ovf_stable_buffer", 32'(out_buffer), 32'h2AAAAAAA);
    out_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Idle timeout flush of a partial buffer.
    expect_pkt(4'd3, 30'h39);
    send_code(2'b11);
    send_code(2'b10);
    send_code(2'b01);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check("timeout_latency", 32'(n), 32'd64);
    wait_drain("timeout_drain");

    // 16th code lands in the buffer being launched.
    expect_pkt(4'd15, 30'h15555555);
    expect_pkt(4'd1, 30'h3);
    for (int i = 0; i < 15; i++) send_code(2'b01);
    send_code(2'b11);
    tick();
    check("wrap_busy", 32'(busy), 32'd1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_drain("wrap_drain");

    // Flush of an empty buffer does nothing.
    check("empty_busy_before", 32'(busy), 32'd0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("empty_busy_after", 32'(busy), 32'd0);
    repeat (5) tick();
    check("empty_no_packet", 32'(out_valid), 32'd0);

    // Flush of a 5-entry buffer.
    expect_pkt(4'd5, 30'h155);
    for (int i = 0; i < 5; i++) send_code(2'b01);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    check("flush5_valid", 32'(out_valid), 32'd1);
    check("flush5_count", 32'(out_count), 32'd5);
    wait_drain("flush5_drain");

    // End-of-test drain with a 10-cycle sink stall; codes during drain are ignored.
    out_ready = 1'b0;
    expect_pkt(4'd7, 30'h2AAA);
    for (int i = 0; i < 7; i++) send_code(2'b10);
    test_ending = 1'b1;
    tick();
    dct_code  = 2'b11;
    dct_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("drain_launch", 32'(out_valid), 32'd1);
    repeat (10) tick();
    check("drain_held_count", 32'(out_count), 32'd7);
    check("drain_held_buffer", 32'(out_buffer), 32'h2AAA);
    check("drain_not_ended", 32'(test_has_ended), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_valid_drop", 32'(out_valid), 32'd0);
    check("drain_ended_early", 32'(test_has_ended), 32'd0);
    tick();
    check("drain_ended", 32'(test_has_ended), 32'd1);
    check("drain_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("drain_ended_hold", 32'(test_has_ended), 32'd1);
    check("drain_no_packet", 32'(out_valid), 32'd0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    dct_valid = 1'b0;

    reset = 1'b1;
    tick();
    check_all_zero("final_reset");
    reset = 1'b0;
    test_ending = 1'b0;
    repeat (3) tick();
    check("post_reset_ended", 32'(test_has_ended), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
